// File: rtl/bus_arbiter4.sv
// bus_arbiter4: round-robin arbiter sharing one bus among four requesters
// (bit 0 = CPU, then DMA, video fetch, debug port).
// Grants are one-hot and registered. sel names the current or last owner.
// A fixed turnaround gap separates consecutive owners.
// Optional hold timeout is compiled in with the macro ARB_TIMEOUT_EN.
// Without that macro, timeout is tied low and an owner may hold forever.
module bus_arbiter4 #(
  parameter int          TURN     = 1,
  parameter logic [7:0]  HOLD_MAX = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  // Turnaround counter load value; never used when TURN is 0.
  localparam logic [1:0] TURN_LOAD = (TURN > 0) ? 2'(TURN - 1) : 2'd0;

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;
  logic [1:0] r_turnCnt;
  logic [1:0] w_winner;
  logic       w_anyReq;
  logic       w_holdExpired;

  // Scan ptr+1, ptr+2, ptr+3, ptr and return the first requester found.
  function automatic logic [1:0] pickWinner(input logic [3:0] reqs,
                                            input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    pickWinner = ptr;
    found      = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && reqs[idx]) begin
        pickWinner = idx;
        found      = 1'b1;
      end
    end
  endfunction

  assign w_anyReq = |req;
  assign w_winner = pickWinner(req, r_ptr);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold;
  logic       r_timeout;

  assign w_holdExpired = req[r_sel] && (r_hold == HOLD_MAX);
  assign timeout       = r_timeout;

  // Hold counter and timeout pulse.
  // The counter restarts on every new grant.
  // A release in the same cycle the count reaches HOLD_MAX is a normal
  // release and does not raise timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == S_IDLE) begin
        r_hold <= 8'd0;
      end else if (r_state == S_GRANT) begin
        if (w_holdExpired) begin
          r_timeout <= 1'b1;
        end else if (req[r_sel]) begin
          r_hold <= r_hold + 8'd1;
        end
      end
    end
  end
`else
  logic w_unusedHoldMax;

  assign w_unusedHoldMax = ^HOLD_MAX;
  assign w_holdExpired   = 1'b0;
  assign timeout         = 1'b0;
`endif

  // Arbitration FSM: pick the winner in IDLE, hold while owned, then turnaround.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= 4'b0000;
      r_sel     <= 2'd0;
      r_ptr     <= 2'd3;
      r_turnCnt <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_gnt   <= 4'b0001 << w_winner;
            r_sel   <= w_winner;
            r_ptr   <= w_winner;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!req[r_sel] || w_holdExpired) begin
            r_gnt <= 4'b0000;
            if (TURN > 0) begin
              r_state   <= S_TURN;
              r_turnCnt <= TURN_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_TURN: begin
          if (r_turnCnt == 2'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_turnCnt <= r_turnCnt - 2'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= 4'b0000;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: directed bench for bus_arbiter4.
// One instance uses TURN=1 and HOLD_MAX=4.
// A second instance uses TURN=0.
// The timeout scenario is compiled when ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  logic       rst0;
  logic [3:0] req0;
  logic [3:0] gnt0;
  logic [1:0] sel0;
  logic       busy0;
  logic       timeout0;

  int checks   = 0;
  int failures = 0;

  bus_arbiter4 #(.TURN(1), .HOLD_MAX(8'd4)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .sel(sel), .busy(busy), .timeout(timeout)
  );

  bus_arbiter4 #(.TURN(0), .HOLD_MAX(8'd4)) dut0 (
    .clk(clk), .rst(rst0), .req(req0), .gnt(gnt0),
    .sel(sel0), .busy(busy0), .timeout(timeout0)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] newReq);
    req = newReq;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst  = 1'b1;
    rst0 = 1'b1;
    req  = 4'b0000;
    req0 = 4'b0000;
    tick();
    tick();
    checkOutput("reset_gnt", 8'(gnt), 8'h00);
    checkOutput("reset_sel", 8'(sel), 8'h00);
    checkOutput("reset_busy", 8'(busy), 8'h00);
    checkOutput("reset_timeout", 8'(timeout), 8'h00);
    rst  = 1'b0;
    rst0 = 1'b0;

    // Single request, release, one turnaround cycle.
    applyStimulus(4'b0001);
    tick();
    checkOutput("t1_gnt", 8'(gnt), 8'h01);
    checkOutput("t1_sel", 8'(sel), 8'h00);
    checkOutput("t1_busy", 8'(busy), 8'h01);
    applyStimulus(4'b0000);
    tick();
    checkOutput("t1_rel_gnt", 8'(gnt), 8'h00);
    checkOutput("t1_turn_busy", 8'(busy), 8'h01);
    tick();
    checkOutput("t1_idle_busy", 8'(busy), 8'h00);

    // All four requesting; each owner releases after 3 cycles and re-requests.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(4'b1111);
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        checkOutput($sformatf("rr%0d_gnt_c%0d", i, c), 8'(gnt),
                    8'(4'b0001 << order[i]));
        checkOutput($sformatf("rr%0d_sel_c%0d", i, c), 8'(sel), 8'(order[i]));
      end
      req[order[i]] = 1'b0;
      tick();
      checkOutput($sformatf("rr%0d_gap1", i), 8'(gnt), 8'h00);
      req[order[i]] = 1'b1;
      tick();
      checkOutput($sformatf("rr%0d_gap2", i), 8'(gnt), 8'h00);
    end
    applyStimulus(4'b0000);
    tick();

    // No preemption: owner 2 keeps the bus while req[1] waits.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(4'b0100);
    tick();
    checkOutput("np_gnt2", 8'(gnt), 8'h04);
    applyStimulus(4'b0110);
    tick();
    checkOutput("np_hold_a", 8'(gnt), 8'h04);
    checkOutput("np_sel", 8'(sel), 8'h02);
    tick();
    checkOutput("np_hold_b", 8'(gnt), 8'h04);
    applyStimulus(4'b0010);
    tick();
    checkOutput("np_rel", 8'(gnt), 8'h00);
    tick();
    checkOutput("np_idle_gnt", 8'(gnt), 8'h00);
    checkOutput("np_idle_sel", 8'(sel), 8'h02);
    tick();
    checkOutput("np_gnt1", 8'(gnt), 8'h02);
    checkOutput("np_sel1", 8'(sel), 8'h01);
    applyStimulus(4'b0000);
    tick();
    tick();

    // A req[3] pulse that drops during a grant is never granted.
    applyStimulus(4'b0100);
    tick();
    checkOutput("tr_gnt2", 8'(gnt), 8'h04);
    applyStimulus(4'b1100);
    tick();
    applyStimulus(4'b0100);
    tick();
    applyStimulus(4'b0000);
    tick();
    tick();
    tick();
    checkOutput("tr_no_gnt", 8'(gnt), 8'h00);
    checkOutput("tr_sel_hold", 8'(sel), 8'h02);
    checkOutput("tr_busy", 8'(busy), 8'h00);

    // Reset while requester 3 owns the bus.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(4'b1000);
    tick();
    checkOutput("rg_gnt3", 8'(gnt), 8'h08);
    checkOutput("rg_sel3", 8'(sel), 8'h03);
    rst = 1'b1;
    tick();
    checkOutput("rg_gnt", 8'(gnt), 8'h00);
    checkOutput("rg_sel", 8'(sel), 8'h00);
    checkOutput("rg_busy", 8'(busy), 8'h00);
    rst = 1'b0;
    applyStimulus(4'b1001);
    tick();
    checkOutput("rg_first", 8'(gnt), 8'h01);
    applyStimulus(4'b0000);
    tick();
    tick();

    // TURN=0 instance: a single idle cycle between owners.
    req0 = 4'b0011;
    tick();
    checkOutput("t0_gnt0", 8'(gnt0), 8'h01);
    req0 = 4'b0010;
    tick();
    checkOutput("t0_gap", 8'(gnt0), 8'h00);
    checkOutput("t0_gap_busy", 8'(busy0), 8'h00);
    tick();
    checkOutput("t0_gnt1", 8'(gnt0), 8'h02);
    checkOutput("t0_sel1", 8'(sel0), 8'h01);
    req0 = 4'b0000;
    tick();
    checkOutput("t0_rel", 8'(gnt0), 8'h00);

    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef ARB_TIMEOUT_EN
    // Hold timeout with HOLD_MAX=4: five grant cycles, then a forced release.
    applyStimulus(4'b0100);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput($sformatf("to_gnt_c%0d", c), 8'(gnt), 8'h04);
      checkOutput($sformatf("to_pulse_c%0d", c), 8'(timeout), 8'h00);
    end
    tick();
    checkOutput("to_drop_gnt", 8'(gnt), 8'h00);
    checkOutput("to_pulse", 8'(timeout), 8'h01);
    checkOutput("to_busy", 8'(busy), 8'h01);
    tick();
    checkOutput("to_pulse_end", 8'(timeout), 8'h00);
    tick();
    checkOutput("to_regrant", 8'(gnt), 8'h04);
    applyStimulus(4'b1100);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput($sformatf("to2_gnt_c%0d", c), 8'(gnt), 8'h04);
    end
    tick();
    checkOutput("to2_pulse", 8'(timeout), 8'h01);
    tick();
    tick();
    checkOutput("to2_next", 8'(gnt), 8'h08);
    checkOutput("to2_sel", 8'(sel), 8'h03);
    for (int c = 0; c < 4; c++) begin
      tick();
    end
    applyStimulus(4'b0000);
    tick();
    checkOutput("to3_rel_gnt", 8'(gnt), 8'h00);
    checkOutput("to3_no_pulse", 8'(timeout), 8'h00);
`else
    // Without the timeout feature an owner may hold the bus indefinitely.
    applyStimulus(4'b0100);
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput($sformatf("nt_gnt_c%0d", c), 8'(gnt), 8'h04);
      checkOutput($sformatf("nt_timeout_c%0d", c), 8'(timeout), 8'h00);
    end
`endif
    applyStimulus(4'b0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4.md
Name: bus_arbiter4

Overview:
- Round-robin arbiter sharing one bus resource, e.g. the memory/IO data path, among 4 requesters: Z80 CPU, DMA, video fetch and debug port.
- Drives a 2-bit select that feeds the 4-way data mux, plus one-hot grants to the requesters.
- Owns bus sequencing: request/grant handshake, hold while owned, fixed turnaround gap between owners.

Parameters:
- TURN, default 1: dead cycles between grant release and next arbitration, range 0..3.
- HOLD_MAX, default 255: max cycles one owner may hold the bus; used only with ARB_TIMEOUT_EN; 8-bit.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  4  request per requester; bit 0 = CPU. Held high for the whole transaction.
- gnt  output  4  one-hot grant, registered; all-zero when no owner.
- sel  output  2  index of current or last owner; drives the mux select.
- busy  output  1  high when state is not IDLE.
- timeout  output  1  one-cycle pulse when a hold is forcibly ended; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values, applied on the first clk edge with rst=1:
  - gnt=0000, sel=00, busy=0, timeout=0, state=IDLE.
  - last-owner pointer ptr=3, so requester 0 wins first.
  - hold counter=0, turnaround counter=0.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req!=0, pick winner = first set bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Next edge: gnt=onehot(winner), sel=winner, ptr=winner, state=GRANT.
  - Latency req to gnt is 1 cycle from IDLE.
  - If req==0, stay in IDLE; sel holds its previous value, so the mux stays stable.
- GRANT:
  - gnt and sel are stable while req[sel]=1.
  - Requests on other bits are ignored (no preemption).
  - When req[sel]=0 is sampled: next edge gnt=0000.
    - TURN>0: state=TURN, turnaround counter loaded with TURN-1.
    - TURN=0: state=IDLE.
- TURN:
  - gnt=0000; counter decrements each cycle.
  - At 0, next edge state=IDLE.
  - Minimum gap from gnt falling to next gnt rising is TURN+1 cycles, of which 1 is the IDLE arbitration cycle.
- Fairness:
  - A requester that releases and immediately re-requests is scanned last.
  - With all 4 requesting continuously, grant order is 0,1,2,3,0...
- Transient requests:
  - A req pulse that drops before IDLE samples it is never granted.
  - A req that rises during GRANT or TURN waits in line; nothing is lost.
- gnt never has more than 1 bit set. sel never changes while gnt!=0.
- Reset during GRANT or TURN: next edge returns all outputs to their reset values; the owner loses the bus immediately.
- busy=1 in GRANT and TURN.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The hold counter clears on entry to GRANT and increments each GRANT cycle while req[sel]=1.
  - When the counter reaches HOLD_MAX with req[sel] still 1:
    - Next edge gnt=0000, timeout=1 for exactly 1 cycle.
    - State goes to TURN, or to IDLE if TURN=0.
  - The timed-out requester may keep req high. It is treated as a new request, with rotation applied from ptr=its index.
  - Release on the same cycle the count hits HOLD_MAX is a normal release: timeout stays 0.
- Undefined: no hold counter logic; timeout tied 0; an owner may hold the bus indefinitely.

Test Plan:
- Reset then req=0001 -> gnt=0001, sel=00 one cycle later; drop req[0] -> gnt=0000 next edge, busy=1 for 1 TURN cycle, then busy=0.
- req=1111 held, each owner drops and re-raises after 3 cycles of ownership -> grant order 0,1,2,3,0; gnt one-hot throughout; TURN+1 gap between grants.
- Owner 2 active, req[1] asserted mid-grant -> no preemption; gnt=0100 until req[2] drops, then gnt=0010 after 2 cycles (TURN=1).
- TURN=0, req=0011 -> gnt=0001; release -> gnt=0000 for 1 cycle, then gnt=0010.
- rst=1 asserted while gnt=1000 -> next edge gnt=0000, sel=00, busy=0; after release with req=1001 -> gnt=0001 first.
- ARB_TIMEOUT_EN, HOLD_MAX=4, req=0100 held -> gnt=0100 for 5 cycles, timeout=1 for 1 cycle as gnt drops, re-granted after turnaround; req=1100 -> requester 3 granted next.
